// File: rtl/sat_pkg.sv
// ============================================================================
// Module   : sat_pkg
// Brief    : Shared types, constants and literal checker for the tinysat
//            clause loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sat_pkg;

    typedef logic signed [4:0] lit_t;

    localparam int   NVARS_DEF = 4;
    localparam lit_t LIT_TERM  = 5'sd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        WAIT   = 3'd4,
        REPORT = 3'd5
    } state_t;

    // -16 has magnitude 16, so the second term rejects it for any NVARS.
    function automatic logic lit_legal(input lit_t lit, input int nvars);
        int mag;
        mag = (lit < 0) ? -int'(lit) : int'(lit);
        return (mag <= nvars) && (mag < 16);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_lit_fifo.sv
// ============================================================================
// Module   : sat_lit_fifo
// Brief    : Single-clock DEPTH x 5-bit literal FIFO with occupancy count and
//            synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_lit_fifo
    import sat_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  lit_t                     din,
    input  logic                     pop,
    output lit_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int           c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE = (c_AW+1)'(1);

    lit_t          r_mem [DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= din;
    end

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign dout  = r_mem[r_rptr[c_AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign count = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: rtl/sat_clause_loader.sv
// ============================================================================
// Module   : sat_clause_loader
// Brief    : Buffers and checks a host CNF literal stream, replays it into the
//            tinysat solver, runs it and returns the result. Optional solver
//            watchdog enabled by defining LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_clause_loader
    import sat_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NVARS   = NVARS_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  lit_t             in_lit,
    input  logic             in_last,
    output logic             sat_load,
    output lit_t             sat_data,
    output logic             sat_run,
    input  logic             sat_done,
    input  logic             sat_sol,
    input  logic [NVARS-1:0] sat_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sol,
    output logic [NVARS-1:0] res_x,
    output logic             res_err,
    output logic             res_tout
);

    localparam int            c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_CNT_LAST = (c_AW+1)'(DEPTH - 1);

    state_t           r_state, w_state_nxt;
    logic             r_err, w_err_nxt;
    logic             r_sol, w_sol_nxt;
    logic [NVARS-1:0] r_x, w_x_nxt;
    logic             r_append, w_append_nxt;
    logic             r_sat_load, w_sat_load_nxt;
    lit_t             r_sat_data, w_sat_data_nxt;

    logic             w_push, w_pop, w_clr;
    lit_t             w_fifo_dout;
    logic             w_full, w_empty;
    logic [c_AW:0]    w_count;
    logic             w_in_ready, w_accept, w_lit_ok;

`ifdef LOADER_TIMEOUT_EN
    localparam logic [9:0] c_TOUT_LAST = 10'(TIMEOUT - 1);
    logic       r_tout, w_tout_nxt;
    logic [9:0] r_cnt, w_cnt_nxt;
`endif

    sat_lit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .push  (w_push),
        .din   (in_lit),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Once an overflow is flagged, further literals are swallowed so the host
    // can finish its formula instead of stalling forever on a full FIFO.
    assign w_in_ready = (r_state == IDLE) ||
                        ((r_state == FILL) && (!w_full || r_err));
    assign w_accept   = in_valid && w_in_ready;
    assign w_lit_ok   = lit_legal(in_lit, NVARS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_err      <= 1'b0;
            r_sol      <= 1'b0;
            r_x        <= '0;
            r_append   <= 1'b0;
            r_sat_load <= 1'b0;
            r_sat_data <= LIT_TERM;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_err_nxt;
            r_sol      <= w_sol_nxt;
            r_x        <= w_x_nxt;
            r_append   <= w_append_nxt;
            r_sat_load <= w_sat_load_nxt;
            r_sat_data <= w_sat_data_nxt;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_tout <= w_tout_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_err_nxt      = r_err;
        w_sol_nxt      = r_sol;
        w_x_nxt        = r_x;
        w_append_nxt   = r_append;
        w_sat_load_nxt = 1'b0;
        w_sat_data_nxt = LIT_TERM;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_clr          = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        w_tout_nxt     = r_tout;
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            IDLE, FILL: begin
                // Full while still filling means the formula cannot fit.
                if ((r_state == FILL) && w_full) w_err_nxt = 1'b1;
                if (w_accept) begin
                    if (r_state == IDLE) w_state_nxt = FILL;
                    if (!w_lit_ok || w_full) w_err_nxt = 1'b1;
                    else                     w_push    = 1'b1;
                    if (in_last) begin
                        w_append_nxt = w_lit_ok && (in_lit != LIT_TERM);
                        // The appended terminator needs a free slot after this write.
                        if (w_lit_ok && !w_full && (in_lit != LIT_TERM) &&
                            (w_count == c_CNT_LAST))
                            w_err_nxt = 1'b1;
                        w_state_nxt = w_err_nxt ? REPORT : LOAD;
                    end
                end
            end
            LOAD: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_sat_load_nxt = 1'b1;
                    w_sat_data_nxt = w_fifo_dout;
                end else if (r_append) begin
                    w_sat_load_nxt = 1'b1;
                    w_sat_data_nxt = LIT_TERM;
                    w_append_nxt   = 1'b0;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = WAIT;
`ifdef LOADER_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            WAIT: begin
                if (sat_done) begin
                    w_sol_nxt   = sat_sol;
                    w_x_nxt     = sat_sol ? sat_x : '0;
                    w_state_nxt = REPORT;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (r_cnt == c_TOUT_LAST) begin
                    w_tout_nxt  = 1'b1;
                    w_sol_nxt   = 1'b0;
                    w_x_nxt     = '0;
                    w_state_nxt = REPORT;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
`endif
            end
            REPORT: begin
                if (res_ready) begin
                    w_err_nxt    = 1'b0;
                    w_sol_nxt    = 1'b0;
                    w_x_nxt      = '0;
                    w_append_nxt = 1'b0;
                    w_clr        = 1'b1;
                    w_state_nxt  = IDLE;
`ifdef LOADER_TIMEOUT_EN
                    w_tout_nxt   = 1'b0;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign sat_load  = r_sat_load;
    assign sat_data  = r_sat_data;
    assign sat_run   = (r_state == RUN) || (r_state == WAIT);
    assign res_valid = (r_state == REPORT);
    assign res_err   = r_err && (r_state == REPORT);
    assign res_sol   = r_sol;
    assign res_x     = r_x;
`ifdef LOADER_TIMEOUT_EN
    assign res_tout  = r_tout;
`else
    assign res_tout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sat_clause_loader.sv
// ============================================================================
// Module   : tb_sat_clause_loader
// Brief    : Randomized self-checking bench for sat_clause_loader against a
//            list-level reference model; watchdog case with LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sat_clause_loader;
    import sat_pkg::*;

    localparam int DEPTH   = 16;
    localparam int NVARS   = 4;
    localparam int TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, in_ready;
    lit_t       in_lit;
    logic       sat_load, sat_run, sat_done, sat_sol;
    lit_t       sat_data;
    logic [3:0] sat_x, res_x;
    logic       res_valid, res_ready, res_sol, res_err, res_tout;

    always #5 clk = ~clk;

    sat_clause_loader #(.DEPTH(DEPTH), .NVARS(NVARS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_lit(in_lit), .in_last(in_last),
        .sat_load(sat_load), .sat_data(sat_data), .sat_run(sat_run),
        .sat_done(sat_done), .sat_sol(sat_sol), .sat_x(sat_x),
        .res_valid(res_valid), .res_ready(res_ready), .res_sol(res_sol),
        .res_x(res_x), .res_err(res_err), .res_tout(res_tout)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_test = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL [t%0d] %s: got %0d expected %0d", cur_test, tag, $signed(got), $signed(exp));
        end
    endtask

    // Solver stand-in: answers cfg_lat cycles after run rises, garbage otherwise.
    bit         cfg_done_en = 1'b1;
    bit         cfg_sol     = 1'b0;
    logic [3:0] cfg_x       = 4'h0;
    int         cfg_lat     = 0;

    initial begin
        int lat;
        lat = 0; sat_done = 1'b0; sat_sol = 1'b0; sat_x = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (sat_run && cfg_done_en && lat >= cfg_lat) begin
                sat_done = 1'b1; sat_sol = cfg_sol; sat_x = cfg_x;
            end else begin
                if (sat_run) lat++; else lat = 0;
                sat_done = 1'b0; sat_sol = 1'($urandom); sat_x = 4'($urandom);
            end
        end
    end

    // Observation of the solver port and back-pressure.
    int got_q[$];
    int run_rise = 0, run_cycles = 0, bp_viol = 0;
    bit prev_run = 1'b0;
    bit stall_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sat_load) got_q.push_back(int'($signed(sat_data)));
            if (sat_run && !prev_run) run_rise++;
            if (sat_run) run_cycles++;
            prev_run = sat_run;
            if (in_ready && (sat_load || sat_run || res_valid)) bp_viol++;
        end
    end

    function automatic bit ref_legal(input int l);
        return (l >= -NVARS) && (l <= NVARS);
    endfunction

    function automatic int rand_lit();
        int r, v;
        r = int'($urandom_range(0, 29));
        if (r == 0) begin
            v = int'($urandom_range(5, 16));
            return ($urandom_range(0, 1) == 1 && v < 16) ? v : -v;
        end
        if (r < 8) return 0;
        v = int'($urandom_range(1, NVARS));
        return ($urandom_range(0, 1) == 1) ? v : -v;
    endfunction

    task automatic send_lit(input int l, input bit last);
        bit acc;
        int n;
        acc = 1'b0; n = 0;
        in_valid = 1'b1; in_lit = 5'(l); in_last = last;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; in_last = 1'b0; in_lit = '0;
    endtask

    task automatic send_formula(input int lits[$], input int gapmax);
        for (int i = 0; i < lits.size(); i++) begin
            send_lit(lits[i], i == lits.size() - 1);
            repeat (int'($urandom_range(0, gapmax))) begin @(posedge clk); #1; end
        end
    endtask

    task automatic get_result(input bit e_err, input bit e_sol, input logic [3:0] e_x, input bit e_tout);
        int n;
        n = 0;
        while (!res_valid && n < 3000) begin @(posedge clk); #1; n++; end
        if (!res_valid) begin
            check("res_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (int'($urandom_range(0, 3))) begin @(posedge clk); #1; end
        check("res_err",  32'(res_err),  32'(e_err));
        check("res_sol",  32'(res_sol),  32'(e_sol));
        check("res_x",    32'(res_x),    32'(e_x));
        check("res_tout", 32'(res_tout), 32'(e_tout));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_drop", 32'(res_valid), 32'd0);
    endtask

    task automatic run_formula(input int lits[$], input bit sol, input logic [3:0] x,
                               input int lat, input int gapmax);
        int  exp_q[$];
        bit  exp_err;
        int  last;
        exp_err = 1'b0;
        foreach (lits[i]) begin
            if (!ref_legal(lits[i])) exp_err = 1'b1;
            else exp_q.push_back(lits[i]);
        end
        last = lits[lits.size() - 1];
        if (ref_legal(last) && last != 0) exp_q.push_back(0);
        if (exp_q.size() > DEPTH) exp_err = 1'b1;
        if (exp_err) exp_q.delete();

        cfg_done_en = 1'b1; cfg_sol = sol; cfg_x = x; cfg_lat = lat;
        got_q.delete(); run_rise = 0; bp_viol = 0; stall_seen = 1'b0;

        send_formula(lits, gapmax);
        get_result(exp_err, exp_err ? 1'b0 : sol, (exp_err || !sol) ? 4'h0 : x, 1'b0);

        check("load_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("load_data", 32'(got_q[i]), 32'(exp_q[i]));
        check("run_pulses", 32'(run_rise), exp_err ? 32'd0 : 32'd1);
        check("backpressure", 32'(bp_viol), 32'd0);
    endtask

    initial begin
        int q[$];
        rst = 1'b1; in_valid = 1'b0; in_lit = '0; in_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_sat_load",  32'(sat_load),  32'd0);
        check("rst_sat_data",  32'(sat_data),  32'd0);
        check("rst_sat_run",   32'(sat_run),   32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res",       32'({res_sol, res_x, res_err, res_tout}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        cur_test = 1; q = '{1, -2, 0, 2, 3, 0};
        run_formula(q, 1'b1, 4'b0101, 2, 0);
        cur_test = 2; q = '{1, 0, -1, 0};
        run_formula(q, 1'b0, 4'b1111, 0, 0);
        cur_test = 3; q = '{1, 5, 0};
        run_formula(q, 1'b1, 4'b0011, 1, 0);

        cur_test = 4; q.delete();
        for (int i = 0; i <= DEPTH; i++) q.push_back(1);
        run_formula(q, 1'b1, 4'b0001, 1, 0);
        check("full_stall", 32'(stall_seen), 32'd1);
        q = '{2, 0};
        run_formula(q, 1'b1, 4'b0010, 3, 0);

        cur_test = 5; q = '{3};
        run_formula(q, 1'b1, 4'b0100, 0, 0);

        // Exactly DEPTH entries with appended terminator, then one too many.
        cur_test = 6; q.delete();
        for (int i = 0; i < DEPTH - 1; i++) q.push_back(2);
        run_formula(q, 1'b1, 4'b1010, 1, 0);
        q.push_back(-3);
        run_formula(q, 1'b1, 4'b1010, 1, 0);

        cur_test = 7;
        for (int t = 0; t < 40; t++) begin
            int len;
            q.delete();
            len = int'($urandom_range(1, DEPTH + 2));
            for (int i = 0; i < len; i++) q.push_back(rand_lit());
            run_formula(q, 1'($urandom), 4'($urandom), int'($urandom_range(0, 4)), 2);
        end

`ifdef LOADER_TIMEOUT_EN
        cur_test = 8; q = '{1, 0};
        cfg_done_en = 1'b0; run_cycles = 0;
        send_formula(q, 0);
        get_result(1'b0, 1'b0, 4'h0, 1'b1);
        check("tout_cycles", 32'(run_cycles), 32'(TIMEOUT + 1));
        cfg_done_en = 1'b1;
`endif

        // Reset in the middle of LOAD must clear the outputs immediately.
        cur_test = 9; q = '{1, 2, 3, 4, 0};
        send_formula(q, 0);
        begin
            int n;
            n = 0;
            while (!sat_load && n < 20) begin @(posedge clk); #1; n++; end
            check("load_seen", 32'(sat_load), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_sat_load",  32'(sat_load),  32'd0);
        check("arst_sat_data",  32'(sat_data),  32'd0);
        check("arst_sat_run",   32'(sat_run),   32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
